// File: rtl/aud_recorder_multi.sv
// aud_recorder_multi: I2S capture engine feeding the SRAM writer.
// Optional peak meter enabled by defining AUD_REC_PEAK_EN.
module aud_recorder_multi #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int STEREO = 0,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_we,
  output logic [ADDR_W:0]   o_len,
  output logic              o_full,
  output logic              o_rec,
  output logic [DATA_W-1:0] o_peak
);

  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t            state;
  logic              lrc_q;
  logic              busy;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              stop_pend;
  logic              pause_pend;

  logic ch_edge;
  logic left_edge;
  logic right_edge;
  logic qual;
  logic stop_req;
  logic pause_req;
  logic last;
  logic hit_full;
  logic bit_in;
  logic lsb;
  logic new_rec;
  logic cap_go;

  assign ch_edge    = i_lrc ^ lrc_q;
  assign left_edge  = lrc_q & ~i_lrc;
  assign right_edge = ~lrc_q & i_lrc;
  assign qual       = left_edge | ((STEREO != 0) & right_edge);
  assign stop_req   = stop_pend | i_stop;
  assign pause_req  = pause_pend | i_pause;
  assign last       = (o_address == MAX_ADDR);
  assign hit_full   = o_we & last;
  assign bit_in     = busy & ~ch_edge;
  assign lsb        = bit_in & (cnt == CW'(DATA_W - 1));
  assign new_rec    = ((state == S_IDLE) || (state == S_DONE))
                    & i_start & ~i_stop & ~i_pause;
  assign o_rec      = (state == S_ARM) || (state == S_RUN);

  // Decide whether a new word capture begins on this cycle's edge
  always_comb begin
    cap_go = 1'b0;
    if (!hit_full) begin
      unique case (state)
        S_ARM:   cap_go = left_edge & ~i_stop & ~i_pause;
        S_RUN:   cap_go = qual & ~(left_edge & (stop_req | pause_req));
        default: cap_go = 1'b0;
      endcase
    end
  end

  // Deserialiser, write bookkeeping and record/pause/stop FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      lrc_q      <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      stop_pend  <= 1'b0;
      pause_pend <= 1'b0;
      o_address  <= '0;
      o_data     <= '0;
      o_we       <= 1'b0;
      o_len      <= '0;
      o_full     <= 1'b0;
    end else begin
      lrc_q <= i_lrc;
      o_we  <= 1'b0;

      if (cap_go) begin
        busy <= 1'b1;
        cnt  <= '0;
      end else if (ch_edge || hit_full) begin
        busy <= 1'b0;
      end else if (bit_in) begin
        shreg <= {shreg[DATA_W-2:0], i_data};
        cnt   <= cnt + 1'b1;
        if (lsb) begin
          busy   <= 1'b0;
          o_we   <= 1'b1;
          o_data <= {shreg[DATA_W-2:0], i_data};
        end
      end

      if (o_we) begin
        o_len <= o_len + 1'b1;
        if (last) o_full <= 1'b1;
        else      o_address <= o_address + 1'b1;
      end

      if (hit_full) begin
        state      <= S_DONE;
        stop_pend  <= 1'b0;
        pause_pend <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_DONE: begin
            if (new_rec) begin
              state      <= S_ARM;
              o_address  <= '0;
              o_len      <= '0;
              o_full     <= 1'b0;
              stop_pend  <= 1'b0;
              pause_pend <= 1'b0;
            end
          end
          S_ARM: begin
            if (i_stop)         state <= S_DONE;
            else if (i_pause)   state <= S_PAUSE;
            else if (left_edge) state <= S_RUN;
          end
          S_RUN: begin
            if (left_edge && stop_req) begin
              state      <= S_DONE;
              stop_pend  <= 1'b0;
              pause_pend <= 1'b0;
            end else if (left_edge && pause_req) begin
              state      <= S_PAUSE;
              stop_pend  <= 1'b0;
              pause_pend <= 1'b0;
            end else begin
              stop_pend  <= stop_req;
              pause_pend <= pause_req;
            end
          end
          S_PAUSE: begin
            if (i_stop)                  state <= S_DONE;
            else if (i_start && !i_pause) state <= S_ARM;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef AUD_REC_PEAK_EN
  logic [DATA_W-1:0] peak_q;
  logic [DATA_W-1:0] mag;

  // Saturating magnitude of the word currently on the write bus
  always_comb begin
    mag = o_data;
    if (o_data[DATA_W-1]) begin
      if (o_data[DATA_W-2:0] == '0) mag = {1'b0, {(DATA_W-1){1'b1}}};
      else                          mag = -o_data;
    end
  end

  // Peak hold, cleared when a fresh recording starts
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      peak_q <= '0;
    end else if (new_rec) begin
      peak_q <= '0;
    end else if (o_we && (mag > peak_q)) begin
      peak_q <= mag;
    end
  end

  assign o_peak = peak_q;
`else
  assign o_peak = '0;
`endif

endmodule

// File: tb/tb_aud_recorder_multi.sv
// tb_aud_recorder_multi: directed scoreboard bench for aud_recorder_multi.
// Three instances: mono, stereo, and stereo with MAX_ADDR=2.
module tb_aud_recorder_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lrc = 1'b1;
  logic din = 1'b0;
  logic st [3];
  logic pa [3];
  logic sp [3];

  logic [19:0] a0, a1, a2;
  logic [15:0] d0, d1, d2;
  logic        w0, w1, w2;
  logic [20:0] l0, l1, l2;
  logic        f0, f1, f2;
  logic        r0, r1, r2;
  logic [15:0] p0, p1, p2;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] q2[$];

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aud_recorder_multi #(.DATA_W(16), .ADDR_W(20), .STEREO(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(din),
    .i_start(st[0]), .i_pause(pa[0]), .i_stop(sp[0]),
    .o_address(a0), .o_data(d0), .o_we(w0), .o_len(l0),
    .o_full(f0), .o_rec(r0), .o_peak(p0)
  );

  aud_recorder_multi #(.DATA_W(16), .ADDR_W(20), .STEREO(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(din),
    .i_start(st[1]), .i_pause(pa[1]), .i_stop(sp[1]),
    .o_address(a1), .o_data(d1), .o_we(w1), .o_len(l1),
    .o_full(f1), .o_rec(r1), .o_peak(p1)
  );

  aud_recorder_multi #(
    .DATA_W(16), .ADDR_W(20), .STEREO(1), .MAX_ADDR(20'd2)
  ) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(din),
    .i_start(st[2]), .i_pause(pa[2]), .i_stop(sp[2]),
    .o_address(a2), .o_data(d2), .o_we(w2), .o_len(l2),
    .o_full(f2), .o_rec(r2), .o_peak(p2)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ent(input logic [19:0] a,
                                      input logic [15:0] d);
    return {28'd0, a, d};
  endfunction

  always @(negedge clk) begin
    if (rst_n && w0 === 1'b1) begin
      if (q0.size() == 0) check("u0 unexpected we", w0, 0);
      else check("u0 write", ent(a0, d0), q0.pop_front());
    end
    if (rst_n && w1 === 1'b1) begin
      if (q1.size() == 0) check("u1 unexpected we", w1, 0);
      else check("u1 write", ent(a1, d1), q1.pop_front());
    end
    if (rst_n && w2 === 1'b1) begin
      if (q2.size() == 0) check("u2 unexpected we", w2, 0);
      else check("u2 write", ent(a2, d2), q2.pop_front());
    end
  end

  task automatic half(input logic lv, input logic [15:0] w, input int n);
    logic [15:0] s;
    s = w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lrc = lv;
      if (i >= 1 && i <= 16) begin
        din = s[15];
        s = s << 1;
      end else begin
        din = 1'b1;
      end
    end
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    half(1'b0, l, 32);
    half(1'b1, r, 32);
  endtask

  task automatic ctl(input int d, input logic s, input logic p,
                     input logic t);
    @(negedge clk);
    st[d] = s;
    pa[d] = p;
    sp[d] = t;
    @(negedge clk);
    st[d] = 1'b0;
    pa[d] = 1'b0;
    sp[d] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      pa[i] = 1'b0;
      sp[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst addr", a0, 0);
    check("rst data", d0, 0);
    check("rst we", w0, 0);
    check("rst len", l0, 0);
    check("rst full", f0, 0);
    check("rst rec", r0, 0);
    check("rst peak", p0, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    ctl(0, 1, 0, 0);
    check("u0 rec armed", r0, 1);
    q0.push_back(ent(0, 16'h1234));
    q0.push_back(ent(1, 16'h8001));
    q0.push_back(ent(2, 16'h7FFF));
    frame(16'h1234, 16'hDEAD);
    frame(16'h8001, 16'hBEEF);
    frame(16'h7FFF, 16'hCAFE);
    check("u0 len", l0, 3);
    ctl(0, 0, 0, 1);
    frame(16'h0BAD, 16'h0BAD);
    check("u0 stopped", r0, 0);
    check("u0 len after stop", l0, 3);
    check("u0 addr after stop", a0, 3);

    ctl(1, 1, 0, 0);
    q1.push_back(ent(0, 16'hAAAA));
    q1.push_back(ent(1, 16'h5555));
    q1.push_back(ent(2, 16'hAAAA));
    q1.push_back(ent(3, 16'h5555));
    frame(16'hAAAA, 16'h5555);
    frame(16'hAAAA, 16'h5555);
    ctl(1, 0, 0, 1);
    frame(16'h1111, 16'h2222);
    check("u1 stopped", r1, 0);
    check("u1 len", l1, 4);
    ctl(1, 1, 0, 0);
    check("u1 addr restart", a1, 0);
    check("u1 len restart", l1, 0);
    q1.push_back(ent(0, 16'h1357));
    q1.push_back(ent(1, 16'h2468));
    fork
      frame(16'h1357, 16'h2468);
      begin
        repeat (8) @(negedge clk);
        pa[1] = 1'b1;
        @(negedge clk);
        pa[1] = 1'b0;
      end
    join
    frame(16'h3333, 16'h4444);
    frame(16'h3333, 16'h4444);
    check("u1 paused rec", r1, 0);
    check("u1 paused len", l1, 2);
    check("u1 paused addr", a1, 2);
    ctl(1, 1, 0, 0);
    q1.push_back(ent(2, 16'h0ACE));
    q1.push_back(ent(3, 16'h0BDF));
    frame(16'h0ACE, 16'h0BDF);
    ctl(1, 0, 0, 1);
    frame(16'h1111, 16'h2222);
    check("u1 resume len", l1, 4);
    check("u1 resume rec", r1, 0);

    ctl(2, 1, 0, 0);
    q2.push_back(ent(0, 16'h0100));
    q2.push_back(ent(1, 16'h8000));
    q2.push_back(ent(2, 16'h0005));
    frame(16'h0100, 16'h8000);
    frame(16'h0005, 16'h1234);
    frame(16'h0777, 16'h0888);
    check("u2 full", f2, 1);
    check("u2 len", l2, 3);
    check("u2 addr hold", a2, 2);
    check("u2 done", r2, 0);
`ifdef AUD_REC_PEAK_EN
    check("u2 peak", p2, 16'h7FFF);
`else
    check("u2 peak off", p2, 0);
`endif
    ctl(2, 1, 0, 0);
    check("u2 rearm rec", r2, 1);
    check("u2 rearm addr", a2, 0);
    check("u2 rearm len", l2, 0);
    check("u2 rearm full", f2, 0);
    check("u2 rearm peak", p2, 0);
    ctl(2, 0, 0, 1);
    check("u2 stop in arm", r2, 0);

    ctl(0, 1, 0, 0);
    half(1'b0, 16'hFFFF, 9);
    half(1'b1, 16'h0F0F, 32);
    check("u0 glitch len", l0, 0);
    check("u0 glitch rec", r0, 1);
    half(1'b0, 16'hFFFF, 9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst addr", a0, 0);
    check("midrst data", d0, 0);
    check("midrst we", w0, 0);
    check("midrst len", l0, 0);
    check("midrst full", f0, 0);
    check("midrst rec", r0, 0);
    check("midrst peak", p0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    half(1'b0, 16'hFFFF, 20);
    half(1'b1, 16'hFFFF, 32);
    check("u0 idle after rst", r0, 0);

    check("q0 drained", q0.size(), 0);
    check("q1 drained", q1.size(), 0);
    check("q2 drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
